// File: rtl/gf3347_pkg.sv
// Shared constants and types for the GF(3347) arithmetic datapath.
package gf3347_pkg;
  typedef logic [11:0] elem_t;
  typedef logic [23:0] prod_t;

  localparam int          Q_W = 12;
  localparam int          K   = 12;
  localparam elem_t       Q   = 12'd3347;
  localparam logic [12:0] MU  = 13'd5012;
  localparam elem_t       EXP = 12'hD11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/barrett_modmul_3347.sv
// Combinational x*y mod 3347 using a Barrett estimate and up to three
// corrective subtractions.
module barrett_modmul_3347 import gf3347_pkg::*; (
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic [11:0] z
);
  prod_t       p;
  logic [24:0] est;
  elem_t       t;
  prod_t       tq;
  prod_t       r;

  always_comb begin
    p   = prod_t'(x) * prod_t'(y);
    est = 25'(p >> K) * 25'(MU);
    t   = elem_t'(est >> K);
    tq  = prod_t'(t) * prod_t'(Q);
    // The estimate never overshoots, so r is non-negative and below 4Q.
    r   = p - tq;
    if (r >= prod_t'(Q)) r = r - prod_t'(Q);
    if (r >= prod_t'(Q)) r = r - prod_t'(Q);
    if (r >= prod_t'(Q)) r = r - prod_t'(Q);
    z   = elem_t'(r);
  end
endmodule

// File: rtl/modinv_3347.sv
// Modular inverse mod 3347 via Fermat exponentiation a^3345, left-to-right
// square-and-multiply, one shared Barrett multiplier.
//
//   state | meaning
//   IDLE  | ready for an operand
//   SQR   | acc <= acc^2 for exponent bit bit_idx
//   MUL   | acc <= acc*base, exponent bit bit_idx was set
//   DONE  | result presented until out_ready
module modinv_3347 import gf3347_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] din_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] dout_r,
  output logic        dout_err
);
  state_e      state_q, state_d;
  elem_t       acc_q, acc_d;
  elem_t       base_q, base_d;
  logic [3:0]  bit_q, bit_d;
  logic        err_q, err_d;
  elem_t       mm_y, mm_z;

  assign mm_y = (state_q == MUL) ? base_q : acc_q;

  barrett_modmul_3347 u_modmul (
    .x (acc_q),
    .y (mm_y),
    .z (mm_z)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    bit_d   = bit_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (din_a != '0 && din_a < Q) begin
            base_d  = din_a;
            acc_d   = 12'd1;
            bit_d   = 4'd11;
            err_d   = 1'b0;
            state_d = SQR;
          end else begin
            acc_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      SQR: begin
        acc_d = mm_z;
        if (EXP[bit_q])          state_d = MUL;
        else if (bit_q == 4'd0)  state_d = DONE;
        else                     bit_d   = bit_q - 4'd1;
      end
      MUL: begin
        acc_d = mm_z;
        if (bit_q == 4'd0) begin
          state_d = DONE;
        end else begin
          bit_d   = bit_q - 4'd1;
          state_d = SQR;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      bit_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dout_r    = out_valid ? acc_q : '0;
  assign dout_err  = out_valid & err_q;
endmodule

// File: tb/tb_modinv_3347.sv
// Directed and exhaustive checks of the mod-3347 inverse unit and its
// Barrett multiplier.
module tb_modinv_3347;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] din_a;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] dout_r;
  logic        dout_err;

  logic [11:0] mm_x;
  logic [11:0] mm_z;

  int tests = 0;
  int fails = 0;

  modinv_3347 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_r    (dout_r),
    .dout_err  (dout_err)
  );

  barrett_modmul_3347 u_mm (
    .x (mm_x),
    .y (mm_x),
    .z (mm_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [11:0] r;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // lat counts posedges from the acceptance edge (inclusive) until out_valid.
  task automatic do_op(input logic [11:0] a, output logic [11:0] r,
                       output logic e, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    din_a    = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = dout_r;
    e = dout_err;
  endtask

  initial begin
    logic [11:0] r;
    logic        e;
    int          lat;
    int          prod;

    vecs[0] = '{12'd1,    12'd1,    1'b0, 18};
    vecs[1] = '{12'd2,    12'd1674, 1'b0, 18};
    vecs[2] = '{12'd3,    12'd1116, 1'b0, 18};
    vecs[3] = '{12'd1116, 12'd3,    1'b0, 18};
    vecs[4] = '{12'd3346, 12'd3346, 1'b0, 18};
    vecs[5] = '{12'd0,    12'd0,    1'b1, 1};
    vecs[6] = '{12'd3347, 12'd0,    1'b1, 1};
    vecs[7] = '{12'd4095, 12'd0,    1'b1, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din_a     = '0;
    out_ready = 1'b1;
    mm_x      = '0;
    #23;
    check("reset in_ready",  int'(in_ready),  1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset dout_r",    int'(dout_r),    0);
    check("reset dout_err",  int'(dout_err),  0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, r, e, lat);
      check($sformatf("vec a=%0d dout_r", vecs[i].a), int'(r), int'(vecs[i].r));
      check($sformatf("vec a=%0d dout_err", vecs[i].a), int'(e), int'(vecs[i].err));
      check($sformatf("vec a=%0d latency", vecs[i].a), lat, vecs[i].lat);
    end

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    out_ready = 1'b0;
    do_op(12'd2, r, e, lat);
    check("bp latency", lat, 18);
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", int'(out_valid), 1);
      check("bp dout_r",    int'(dout_r),    1674);
      check("bp in_ready",  int'(in_ready),  0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp single handshake", int'(out_valid), 0);
    check("bp in_ready after",   int'(in_ready),  1);

    // Back-to-back with in_valid held high.
    din_a    = 12'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1 din_a = 12'd3;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b first dout_r",   int'(dout_r),   1674);
    check("b2b first latency",  lat,            18);
    check("b2b DONE in_ready",  int'(in_ready), 0);
    @(negedge clk);
    check("b2b idle out_valid", int'(out_valid), 0);
    check("b2b idle in_ready",  int'(in_ready),  1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b second dout_r",  int'(dout_r), 1116);
    check("b2b second latency", lat,          18);

    // Reset in the middle of an exponentiation.
    @(negedge clk);
    @(negedge clk);
    din_a    = 12'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset out_valid", int'(out_valid), 0);
    check("midreset in_ready",  int'(in_ready),  1);
    check("midreset dout_r",    int'(dout_r),    0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(12'd2, r, e, lat);
    check("post-reset dout_r",  int'(r), 1674);
    check("post-reset latency", lat,     18);

    // Exhaustive inverse property.
    for (int a = 1; a < 3347; a++) begin
      do_op(12'(a), r, e, lat);
      prod = (a * int'(r)) % 3347;
      if (e || lat != 18) prod = -1;
      check($sformatf("exhaustive a=%0d (a*r mod q, r=%0d)", a, r), prod, 1);
    end

    // Standalone multiplier over all squares.
    for (int x = 0; x < 3347; x++) begin
      mm_x = 12'(x);
      #1;
      check($sformatf("modmul %0d^2", x), int'(mm_z), (x * x) % 3347);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
